// File: rtl/serdesphy_pkg.sv
// Shared SerDes PHY definitions: PLL sequencer state encoding, status word layout
// and default timing for the 24 MHz reference domain.
package serdesphy_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_ISO       = 3'd1,
        ST_RESET     = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_LOCKED    = 3'd4,
        ST_ERROR     = 3'd5
    } pll_state_t;

    localparam int STATUS_STATE_LSB = 0;
    localparam int STATUS_LOCK_BIT  = 3;
    localparam int STATUS_VCO_BIT   = 4;
    localparam int STATUS_CP_BIT    = 5;
    localparam int STATUS_RETRY_LSB = 6;

    // 24 MHz reference: 24 cycles = 1 us
    localparam int DEF_ISO_CYCLES   = 24;
    localparam int DEF_RST_CYCLES   = 240;
    localparam int DEF_LOCK_TIMEOUT = 24000;
    localparam int DEF_LOCK_STABLE  = 64;
    localparam int DEF_LOL_CYCLES   = 4;
    localparam int DEF_MAX_RETRY    = 3;
    localparam int DEF_CNT_W        = 16;

endpackage

// File: rtl/serdesphy_sync2.sv
// Generic two-flop synchroniser for a single asynchronous level.
module serdesphy_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            q_reg    <= 1'b0;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/serdesphy_pll_ctrl.sv
// TX PLL power-up/lock sequencer: orders enable, isolation and reset release,
// qualifies lock, retries on timeout or loss of lock, and reports status.
module serdesphy_pll_ctrl
    import serdesphy_pkg::*;
#(
    parameter int ISO_CYCLES   = DEF_ISO_CYCLES,
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int LOL_CYCLES   = DEF_LOL_CYCLES,
    parameter int MAX_RETRY    = DEF_MAX_RETRY,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic       clk_ref_24m,
    input  logic       rst_n,
    input  logic       phy_en,
    input  logic       pll_rst,
    input  logic       pll_bypass,
    input  logic [3:0] vco_trim,
    input  logic [1:0] cp_current,
    input  logic       pll_lock_raw,
    input  logic       pll_vco_ok,
    input  logic       pll_cp_ok,
    output logic       pll_enable,
    output logic       pll_iso_n,
    output logic       pll_reset_n,
    output logic       pll_bypass_en,
    output logic [3:0] pll_vco_trim,
    output logic [1:0] pll_cp_current,
    output logic       pll_lock,
    output logic       pll_ready,
    output logic       pll_error,
    output logic [7:0] pll_status,
    output logic       clk_240m_tx_en,
    output logic       clk_240m_rx_en
);

    localparam int STB_W = $clog2(LOCK_STABLE + 1);
    localparam int LOL_W = $clog2(LOL_CYCLES + 1);

    localparam logic [CNT_W-1:0] ISO_LAST     = CNT_W'(ISO_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STABLE_LAST  = STB_W'(LOCK_STABLE - 1);
    localparam logic [LOL_W-1:0] LOL_LAST     = LOL_W'(LOL_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

    // Bit order matches the status word: [0]=lock, [1]=vco_ok, [2]=cp_ok
    logic [2:0] raw_vec;
    logic [2:0] sync_vec;
    logic       qlock;

    assign raw_vec = {pll_cp_ok, pll_vco_ok, pll_lock_raw};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        serdesphy_sync2 u_sync (
            .clk   (clk_ref_24m),
            .rst_n (rst_n),
            .d     (raw_vec[gi]),
            .q     (sync_vec[gi])
        );
    end

    assign qlock = &sync_vec;

    pll_state_t       state_reg, state_next;
    logic [CNT_W-1:0] timer_reg, timer_next;
    logic [STB_W-1:0] stable_reg, stable_next;
    logic [LOL_W-1:0] lol_reg, lol_next;
    logic [1:0]       retry_reg, retry_next;
    logic             bypass_reg, bypass_next;
    logic [3:0]       trim_reg, trim_next;
    logic [1:0]       cp_reg, cp_next;
    logic             load_cfg, clear_cfg, retry_event;

    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg + 1'b1;
        stable_next = stable_reg;
        lol_next    = '0;
        retry_next  = retry_reg;
        load_cfg    = 1'b0;
        clear_cfg   = 1'b0;
        retry_event = 1'b0;
        case (state_reg)
            ST_OFF: begin
                timer_next = '0;
                if (phy_en) begin
                    state_next = ST_ISO;
                    load_cfg   = 1'b1;
                end
            end
            ST_ISO: begin
                if (timer_reg == ISO_LAST) begin
                    state_next = ST_RESET;
                    timer_next = '0;
                    load_cfg   = 1'b1;
                end
            end
            ST_RESET: begin
                stable_next = '0;
                if (timer_reg == RST_LAST) begin
                    state_next = bypass_reg ? ST_LOCKED : ST_WAIT_LOCK;
                    timer_next = '0;
                end
            end
            ST_WAIT_LOCK: begin
                stable_next = qlock ? stable_reg + 1'b1 : '0;
                // Lock completion takes precedence over a coincident timeout
                if (qlock && stable_reg == STABLE_LAST) begin
                    state_next = ST_LOCKED;
                    timer_next = '0;
                end else if (timer_reg == TIMEOUT_LAST) begin
                    retry_event = 1'b1;
                end
            end
            ST_LOCKED: begin
                timer_next  = '0;
                stable_next = '0;
                if (!bypass_reg && !qlock) begin
                    lol_next = lol_reg + 1'b1;
                    if (lol_reg == LOL_LAST) begin
                        retry_event = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                timer_next = '0;
            end
            default: begin
                state_next = ST_OFF;
                timer_next = '0;
            end
        endcase

        if (retry_event) begin
            if (retry_reg < RETRY_MAX) begin
                retry_next = retry_reg + 2'd1;
                state_next = ST_RESET;
                timer_next = '0;
                load_cfg   = 1'b1;
            end else begin
                state_next = ST_ERROR;
                timer_next = '0;
            end
        end

        if (pll_rst) begin
            state_next = ST_RESET;
            timer_next = '0;
            retry_next = '0;
            load_cfg   = 1'b1;
        end

        if (!phy_en) begin
            state_next = ST_OFF;
            timer_next = '0;
            retry_next = '0;
            load_cfg   = 1'b0;
            clear_cfg  = 1'b1;
        end
    end

    always_comb begin
        bypass_next = bypass_reg;
        trim_next   = trim_reg;
        cp_next     = cp_reg;
        if (clear_cfg) begin
            bypass_next = 1'b0;
            trim_next   = '0;
            cp_next     = '0;
        end else if (load_cfg) begin
            bypass_next = pll_bypass;
            trim_next   = vco_trim;
            cp_next     = cp_current;
        end
    end

    // Outputs are decoded from the next state so they change together with it
    logic       enable_next, iso_n_next, reset_n_next;
    logic       lock_next, ready_next, error_next;
    logic [7:0] status_next;

    always_comb begin
        enable_next  = 1'b0;
        iso_n_next   = 1'b0;
        reset_n_next = 1'b0;
        ready_next   = 1'b0;
        error_next   = 1'b0;
        case (state_next)
            ST_ISO:       enable_next = 1'b1;
            ST_RESET:     {enable_next, iso_n_next} = 2'b11;
            ST_WAIT_LOCK: {enable_next, iso_n_next, reset_n_next} = 3'b111;
            ST_LOCKED:    {enable_next, iso_n_next, reset_n_next, ready_next} = 4'b1111;
            ST_ERROR:     error_next = 1'b1;
            default:      enable_next = 1'b0;
        endcase
        lock_next = ready_next & ~bypass_next;

        status_next = '0;
        status_next[STATUS_STATE_LSB +: 3] = state_next;
        status_next[STATUS_LOCK_BIT]       = sync_vec[0];
        status_next[STATUS_VCO_BIT]        = sync_vec[1];
        status_next[STATUS_CP_BIT]         = sync_vec[2];
        status_next[STATUS_RETRY_LSB +: 2] = retry_next;
    end

    logic       enable_reg, iso_n_reg, reset_n_reg;
    logic       lock_reg, ready_reg, error_reg;
    logic [7:0] status_reg;

    always_ff @(posedge clk_ref_24m or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_OFF;
            timer_reg   <= '0;
            stable_reg  <= '0;
            lol_reg     <= '0;
            retry_reg   <= '0;
            bypass_reg  <= 1'b0;
            trim_reg    <= '0;
            cp_reg      <= '0;
            enable_reg  <= 1'b0;
            iso_n_reg   <= 1'b0;
            reset_n_reg <= 1'b0;
            lock_reg    <= 1'b0;
            ready_reg   <= 1'b0;
            error_reg   <= 1'b0;
            status_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            stable_reg  <= stable_next;
            lol_reg     <= lol_next;
            retry_reg   <= retry_next;
            bypass_reg  <= bypass_next;
            trim_reg    <= trim_next;
            cp_reg      <= cp_next;
            enable_reg  <= enable_next;
            iso_n_reg   <= iso_n_next;
            reset_n_reg <= reset_n_next;
            lock_reg    <= lock_next;
            ready_reg   <= ready_next;
            error_reg   <= error_next;
            status_reg  <= status_next;
        end
    end

    assign pll_enable     = enable_reg;
    assign pll_iso_n      = iso_n_reg;
    assign pll_reset_n    = reset_n_reg;
    assign pll_bypass_en  = bypass_reg;
    assign pll_vco_trim   = trim_reg;
    assign pll_cp_current = cp_reg;
    assign pll_lock       = lock_reg;
    assign pll_ready      = ready_reg;
    assign pll_error      = error_reg;
    assign pll_status     = status_reg;
    assign clk_240m_tx_en = ready_reg;
    assign clk_240m_rx_en = ready_reg;

endmodule

// File: tb/tb_serdesphy_pll_ctrl.sv
// Directed/randomised bench for serdesphy_pll_ctrl; expected latencies are
// derived arithmetically from the sequencing rules.
module tb_serdesphy_pll_ctrl;

    localparam int ISO = 24;
    localparam int RST = 240;
    localparam int TMO = 1500;
    localparam int STB = 64;
    localparam int LOL = 4;
    localparam int MR  = 3;

    logic       clk_ref_24m;
    logic       rst_n;
    logic       phy_en, pll_rst, pll_bypass;
    logic [3:0] vco_trim;
    logic [1:0] cp_current;
    logic       pll_lock_raw, pll_vco_ok, pll_cp_ok;
    logic       pll_enable, pll_iso_n, pll_reset_n, pll_bypass_en;
    logic [3:0] pll_vco_trim;
    logic [1:0] pll_cp_current;
    logic       pll_lock, pll_ready, pll_error;
    logic [7:0] pll_status;
    logic       clk_240m_tx_en, clk_240m_rx_en;

    int total = 0;
    int bad   = 0;
    bit ready_seen;

    serdesphy_pll_ctrl #(
        .ISO_CYCLES   (ISO),
        .RST_CYCLES   (RST),
        .LOCK_TIMEOUT (TMO),
        .LOCK_STABLE  (STB),
        .LOL_CYCLES   (LOL),
        .MAX_RETRY    (MR),
        .CNT_W        (16)
    ) dut (
        .clk_ref_24m    (clk_ref_24m),
        .rst_n          (rst_n),
        .phy_en         (phy_en),
        .pll_rst        (pll_rst),
        .pll_bypass     (pll_bypass),
        .vco_trim       (vco_trim),
        .cp_current     (cp_current),
        .pll_lock_raw   (pll_lock_raw),
        .pll_vco_ok     (pll_vco_ok),
        .pll_cp_ok      (pll_cp_ok),
        .pll_enable     (pll_enable),
        .pll_iso_n      (pll_iso_n),
        .pll_reset_n    (pll_reset_n),
        .pll_bypass_en  (pll_bypass_en),
        .pll_vco_trim   (pll_vco_trim),
        .pll_cp_current (pll_cp_current),
        .pll_lock       (pll_lock),
        .pll_ready      (pll_ready),
        .pll_error      (pll_error),
        .pll_status     (pll_status),
        .clk_240m_tx_en (clk_240m_tx_en),
        .clk_240m_rx_en (clk_240m_rx_en)
    );

    initial clk_ref_24m = 1'b0;
    always #20 clk_ref_24m = ~clk_ref_24m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_ref_24m);
    endtask

    // All outputs packed; optionally hide the synchronised analog flags
    function automatic logic [31:0] outs(input bit mask_sync);
        logic [7:0] st;
        st = mask_sync ? (pll_status & 8'hC7) : pll_status;
        return {9'd0, pll_enable, pll_iso_n, pll_reset_n, pll_bypass_en, pll_vco_trim,
                pll_cp_current, pll_lock, pll_ready, pll_error, st,
                clk_240m_tx_en, clk_240m_rx_en};
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return pll_iso_n;
            1:       return pll_reset_n;
            2:       return pll_ready;
            3:       return pll_error;
            4:       return !pll_ready;
            5:       return !pll_reset_n;
            default: return 1'b0;
        endcase
    endfunction

    // Counts falling edges until the selected condition holds; max+1 on timeout
    task automatic wait_sig(input int sel, input int max, input bit glitch, output int n);
        for (n = 1; n <= max; n++) begin
            @(negedge clk_ref_24m);
            if (pll_ready) ready_seen = 1'b1;
            if (sig(sel)) return;
            if (glitch) pll_lock_raw = ((n % 31) != 30);
        end
    endtask

    initial begin
        int n, exp_n, d;
        logic [3:0] trim_a, trim_b, trim_d;
        logic [1:0] cp_a, cp_b;
        bit ready_all;

        rst_n = 1'b0; phy_en = 1'b0; pll_rst = 1'b0; pll_bypass = 1'b0;
        vco_trim = '0; cp_current = '0;
        pll_lock_raw = 1'b0; pll_vco_ok = 1'b0; pll_cp_ok = 1'b0;
        tick(3);
        check("reset_outputs", outs(0), 32'd0);
        rst_n = 1'b1;
        tick(2);
        check("off_idle", outs(0), 32'd0);

        // Nominal bring-up with randomised config and lock arrival
        trim_a = 4'($urandom_range(0, 15)); cp_a = 2'($urandom_range(0, 3));
        vco_trim = trim_a; cp_current = cp_a;
        pll_vco_ok = 1'b1; pll_cp_ok = 1'b1;
        phy_en = 1'b1;
        wait_sig(0, 1 + ISO + 20, 0, n);
        check("iso_release_delay", n, 1 + ISO);
        check("reset_state", pll_status[2:0], 3'd2);
        check("enable_on", pll_enable, 1'b1);
        check("cfg_latched", {pll_bypass_en, pll_vco_trim, pll_cp_current}, {1'b0, trim_a, cp_a});
        wait_sig(1, RST + 20, 0, n);
        check("reset_release_delay", n, RST);
        check("wait_state", pll_status[2:0], 3'd3);
        d = $urandom_range(450, 550);
        tick(d);
        pll_lock_raw = 1'b1;
        wait_sig(2, 2 + STB + 20, 0, n);
        check("lock_to_ready", n, 2 + STB);
        check("locked_status", pll_status, 8'h3C);
        check("locked_flags", {pll_lock, clk_240m_tx_en, clk_240m_rx_en, pll_reset_n}, 4'hF);
        $display("nominal: lock after %0d cycles, ready %0d cycles later", d, n);

        trim_b = ~trim_a; cp_b = ~cp_a;
        vco_trim = trim_b; cp_current = cp_b;
        tick(5);
        check("cfg_ignored_locked", {pll_vco_trim, pll_cp_current}, {trim_a, cp_a});

        // Three-cycle dropout is tolerated
        pll_lock_raw = 1'b0;
        tick(LOL - 1);
        pll_lock_raw = 1'b1;
        ready_all = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            ready_all &= pll_ready;
        end
        check("lol_short_ready", ready_all, 1'b1);

        // Four-cycle dropout triggers a retry
        pll_lock_raw = 1'b0;
        tick(LOL);
        check("lol_ready_held", pll_ready, 1'b1);
        pll_lock_raw = 1'b1;
        wait_sig(4, 20, 0, n);
        check("lol_ready_drop", n + LOL, 2 + LOL);
        check("lol_status", pll_status & 8'hC7, 8'h42);
        check("cfg_relatched", {pll_vco_trim, pll_cp_current}, {trim_b, cp_b});
        $display("loss of lock: ready dropped, retry=%0d", pll_status[7:6]);

        // Glitchy lock never qualifies; timeout costs one retry
        phy_en = 1'b0;
        tick(1);
        check("off_after_disable", outs(1), 32'd0);
        pll_lock_raw = 1'b0;
        phy_en = 1'b1;
        wait_sig(1, 1 + ISO + RST + 20, 0, n);
        check("glitch_bringup", n, 1 + ISO + RST);
        pll_lock_raw = 1'b1;
        ready_seen = 1'b0;
        wait_sig(5, TMO + 20, 1, n);
        check("glitch_timeout", n, TMO);
        check("glitch_status", pll_status & 8'hC7, 8'h42);
        check("glitch_never_ready", ready_seen, 1'b0);
        $display("glitchy lock: timeout after %0d cycles", n);

        // No lock at all: all retries used, then ERROR
        phy_en = 1'b0;
        pll_lock_raw = 1'b0;
        tick(1);
        phy_en = 1'b1;
        exp_n = 1 + ISO + (MR + 1) * (RST + TMO);
        wait_sig(3, exp_n + 20, 0, n);
        check("error_delay", n, exp_n);
        check("error_status", pll_status, 8'hF5);
        check("error_analog_off", {pll_enable, pll_iso_n, pll_reset_n, pll_ready}, 4'h0);
        tick(3);
        check("error_sticky", pll_error, 1'b1);
        trim_d = 4'($urandom_range(0, 15));
        vco_trim = trim_d;
        pll_rst = 1'b1;
        tick(1);
        pll_rst = 1'b0;
        check("rst_clears_error", pll_status & 8'hC7, 8'h02);
        check("rst_error_low", {pll_error, pll_enable, pll_iso_n}, 3'b011);
        check("rst_cfg", pll_vco_trim, trim_d);
        $display("no lock: error after %0d cycles, cleared by pll_rst", n);

        // Bypass: LOCKED straight after RESET without any lock input
        phy_en = 1'b0;
        pll_vco_ok = 1'b0; pll_cp_ok = 1'b0;
        tick(1);
        pll_bypass = 1'b1;
        phy_en = 1'b1;
        wait_sig(2, 1 + ISO + RST + 20, 0, n);
        check("bypass_ready_delay", n, 1 + ISO + RST);
        check("bypass_flags", {pll_bypass_en, pll_lock, pll_ready, clk_240m_tx_en, clk_240m_rx_en}, 5'b10111);
        check("bypass_state", pll_status[2:0], 3'd4);
        pll_bypass = 1'b0;
        ready_all = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            ready_all &= pll_ready & pll_bypass_en;
        end
        check("bypass_toggle_ignored", ready_all, 1'b1);
        $display("bypass: ready after %0d cycles", n);

        // phy_en abort in WAIT_LOCK
        phy_en = 1'b0;
        pll_vco_ok = 1'b1; pll_cp_ok = 1'b1; pll_lock_raw = 1'b0;
        tick(1);
        phy_en = 1'b1;
        wait_sig(1, 1 + ISO + RST + 20, 0, n);
        check("abort_bringup", n, 1 + ISO + RST);
        d = $urandom_range(10, 100);
        tick(d);
        check("abort_in_wait", pll_status[2:0], 3'd3);
        phy_en = 1'b0;
        tick(1);
        check("abort_outputs", outs(1), 32'd0);
        $display("abort: phy_en dropped %0d cycles into WAIT_LOCK", d);

        // Lock already present: ready follows the stable window; then async reset
        pll_lock_raw = 1'b1;
        phy_en = 1'b1;
        wait_sig(2, 1 + ISO + RST + STB + 20, 0, n);
        check("prelock_ready_delay", n, 1 + ISO + RST + STB);
        #3;
        rst_n = 1'b0;
        #2;
        check("async_reset_outputs", outs(0), 32'd0);
        tick(1);
        rst_n = 1'b1;
        phy_en = 1'b0;
        tick(1);
        check("post_reset_off", outs(1), 32'd0);
        $display("async reset: outputs cleared before next edge");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serdesphy_pll_ctrl.md
Name: serdesphy_pll_ctrl

Overview:
- Power-up and lock sequencer for the analog 240 MHz TX PLL. Runs in the 24 MHz reference domain under the PHY enable.
- Orders enable, isolation release and reset release on the PLL. Latches the CSR trim and current settings on each bring-up.
- Qualifies the asynchronous lock indication, retries on timeout or loss of lock, and reports ready, error and status to the CSR block and the clock-enable logic.

Parameters:
- ISO_CYCLES, 24: cycles PLL is enabled before isolation release (1 us).
- RST_CYCLES, 240: cycles PLL reset is held after isolation release (10 us).
- LOCK_TIMEOUT, 24000: cycles allowed in WAIT_LOCK before a retry (1 ms).
- LOCK_STABLE, 64: consecutive qualified-lock cycles required to declare lock.
- LOL_CYCLES, 4: consecutive unlocked cycles in LOCKED that count as loss of lock.
- MAX_RETRY, 3: retries allowed before ERROR; range 1..3.
- CNT_W, 16: width of the shared timer.

Ports:
- clk_ref_24m  in  1  24 MHz reference clock.
- rst_n  in  1  Reset, asynchronous, active-low.
- phy_en  in  1  PHY enable from CSR/POR.
- pll_rst  in  1  CSR PLL reset request (level).
- pll_bypass  in  1  CSR bypass request.
- vco_trim  in  4  CSR VCO trim.
- cp_current  in  2  CSR charge-pump current.
- pll_lock_raw  in  1  Analog lock, asynchronous.
- pll_vco_ok  in  1  Analog VCO range OK, asynchronous.
- pll_cp_ok  in  1  Analog charge pump OK, asynchronous.
- pll_enable  out  1  Analog PLL power enable.
- pll_iso_n  out  1  Analog isolation release (active-low isolation).
- pll_reset_n  out  1  Analog PLL reset (active-low).
- pll_bypass_en  out  1  Latched bypass to analog.
- pll_vco_trim  out  4  Latched trim to analog.
- pll_cp_current  out  2  Latched current to analog.
- pll_lock  out  1  Qualified lock.
- pll_ready  out  1  PLL usable.
- pll_error  out  1  Retries exhausted (sticky).
- pll_status  out  8  Status word.
- clk_240m_tx_en  out  1  TX 240 MHz clock enable.
- clk_240m_rx_en  out  1  RX 240 MHz clock enable.

Behaviour:
- Reset values: state OFF; all outputs 0; retry count 0.
- Synchronisation: pll_lock_raw, pll_vco_ok and pll_cp_ok each pass through a 2-FF synchroniser (2-cycle latency).
- qlock = lock_s & vco_ok_s & cp_ok_s.
- All outputs are registered from state.
- Priority each cycle:
  - phy_en=0 forces OFF next cycle and clears the retry count.
  - Otherwise pll_rst=1 forces RESET with the timer reloaded, clears the retry count and clears ERROR.
  - Otherwise normal transitions apply.
- State OFF: enable=0, iso_n=0, reset_n=0. When phy_en=1, latch vco_trim, cp_current and pll_bypass, then go to ISO.
- State ISO: enable=1. After ISO_CYCLES, go to RESET.
- State RESET: enable=1, iso_n=1, reset_n=0. Re-latch the config on entry. After RST_CYCLES, go to WAIT_LOCK; if the latched bypass is set, go to LOCKED instead.
- State WAIT_LOCK: reset_n=1.
  - Stable counter increments while qlock=1 and clears on any qlock=0.
  - On reaching LOCK_STABLE, go to LOCKED (ready asserts the next cycle).
  - If the timer reaches LOCK_TIMEOUT first and retry < MAX_RETRY: increment retry, go to RESET.
  - Otherwise go to ERROR.
  - Simultaneous stable completion and timeout: lock wins.
- State LOCKED: pll_lock=1 (0 when bypassed), pll_ready=1, both clock enables=1.
  - Not bypassed: LOL counter counts consecutive qlock=0 cycles; at LOL_CYCLES, apply the same retry/ERROR rule as a timeout.
  - Bypassed: lock is not monitored.
- State ERROR: enable=0, iso_n=0, reset_n=0, pll_error=1. Leave only via phy_en=0 or pll_rst=1.
- CSR config changes while not in OFF/RESET are ignored until the next RESET entry.
- Retry count saturates at MAX_RETRY.
- pll_status bit map:
  - [2:0] state encoding: OFF=0, ISO=1, RESET=2, WAIT_LOCK=3, LOCKED=4, ERROR=5.
  - [3] lock_s.
  - [4] vco_ok_s.
  - [5] cp_ok_s.
  - [7:6] retry count.
- Async rst_n assertion at any point returns everything to reset values immediately.

Decomposition:
- Shared serdesphy package holds:
  - the state enum and its encoding;
  - the pll_status bit-index constants;
  - default timing constants (24 MHz based).
- One sub-module, serdesphy_sync2: a generic 2-FF synchroniser, instantiated three times.

Test Plan:
- Nominal bring-up: phy_en rises, pll_lock_raw rises 500 cycles after reset_n release.
  - pll_iso_n rises 24 cycles after ISO entry; pll_reset_n rises 240 cycles later.
  - pll_ready rises 2+64 cycles after lock; status[2:0]=4.
- Glitchy lock: 30-cycle lock pulses with 1-cycle gaps -> never LOCKED; after timeout, retry=1 and status[7:6]=1.
- No lock: lock never asserts -> 3 retries, then ERROR, pll_error=1, enable=0, status=0x?5 with [7:6]=3. Then a 1-cycle pll_rst pulse -> RESET, error clears, retry=0.
- Loss of lock while LOCKED: lock low 3 cycles -> ready stays 1. Lock low 4 cycles -> ready=0 next cycle, state RESET, retry=1.
- Bypass: pll_bypass=1 before phy_en -> LOCKED straight after RESET with no lock input; pll_bypass_en=1, pll_lock=0, pll_ready=1. Toggling pll_bypass while LOCKED has no effect.
- Aborts:
  - phy_en drops mid-WAIT_LOCK -> OFF next cycle with all outputs 0.
  - rst_n asserted mid-LOCKED -> outputs 0 immediately, without waiting for a clock edge.
